// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared types and defaults for the CPU memory-port arbiter.
// Holds the arbiter state and owner enums, the default bus widths and the
// grant-selection helper used by mem_port_arbiter.
package cpu_mem_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_I   = 2'd1,
    RD_D   = 2'd2,
    WR_REC = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  // Data normally wins; fetch wins only when it is promoted or data is idle.
  function automatic owner_t pick_owner(input logic fetch_req,
                                        input logic data_req,
                                        input logic fetch_first);
    if (fetch_req && (fetch_first || !data_req)) begin
      return OWN_I;
    end else if (data_req) begin
      return OWN_D;
    end else begin
      return OWN_NONE;
    end
  endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// mem_arb_starve_cnt: counts consecutive cycles a fetch request is denied,
// saturating at MAX_WAIT. promote is high while the count sits at MAX_WAIT.
// Only instantiated when MEM_ARB_STARVE_GUARD_EN is defined.
module mem_arb_starve_cnt #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req,
  input  logic gnt,
  output logic promote
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear on grant or withdrawn request, otherwise count up and saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (!req || gnt) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Wait-count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign promote = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single synchronous memory port between the
// fetch requester and the load/store requester. One access per cycle, read
// data routed to its owner one cycle after the grant, one idle bubble after
// every store. Define MEM_ARB_STARVE_GUARD_EN to promote fetch after
// MAX_WAIT consecutive denied cycles; otherwise data has strict priority.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_t state_q;
  arb_state_t state_d;
  owner_t     owner;
  logic       promote;

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (i_req),
    .gnt     (i_gnt),
    .promote (promote)
  );
`else
  assign promote = 1'b0;
`endif

  // Read data is always forwarded; rvalid qualifies it.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  // Arbitration, memory-port drive and next state; all outputs forced low in reset.
  always_comb begin
    state_d   = IDLE;
    owner     = OWN_NONE;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    busy      = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (reset_n) begin
      i_rvalid = (state_q == RD_I);
      d_rvalid = (state_q == RD_D);
      busy     = (state_q != IDLE);
      // The store recovery bubble blocks all grants.
      if (state_q != WR_REC) begin
        owner = pick_owner(i_req, d_req, promote);
      end
      case (owner)
        OWN_I: begin
          i_gnt    = 1'b1;
          mem_addr = i_addr;
          state_d  = RD_I;
        end
        OWN_D: begin
          d_gnt     = 1'b1;
          mem_addr  = d_addr;
          mem_wdata = d_wdata;
          mem_we    = d_we;
          state_d   = d_we ? WR_REC : RD_D;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State register; reset drops any read still in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with a behavioural
// synchronous memory. Read-data expectations go into per-owner queues when a
// grant is seen; a monitor pops and compares whenever an rvalid is presented.
module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  logic [DW-1:0] mem [0:65535];
  logic [DW-1:0] iq[$];
  logic [DW-1:0] dq[$];

  int n_chk  = 0;
  int n_pass = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data for the address of cycle N appears in cycle N+1.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented rvalid must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (i_rvalid) begin
        if (iq.size() == 0) chk("i_rvalid_unexpected", 32'd1, 32'd0);
        else chk("i_rdata", {16'h0, i_rdata}, {16'h0, iq.pop_front()});
      end
      if (d_rvalid) begin
        if (dq.size() == 0) chk("d_rvalid_unexpected", 32'd1, 32'd0);
        else chk("d_rdata", {16'h0, d_rdata}, {16'h0, dq.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_i;
    mem[16'h0010] = 16'h1234;
    mem[16'h0012] = 16'h5678;
    mem[16'h0200] = 16'hA5A5;
    mem[16'h0300] = 16'h0000;

    // Reset with requests asserted: every output must stay low.
    reset_n = 1'b0;
    i_req = 1'b1; i_addr = 16'h0010;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0300; d_wdata = 16'hBEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_i_gnt", i_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rvalid", {i_rvalid, d_rvalid}, 0);
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    step();

    // Fetch only, three back-to-back reads of 0x0010.
    i_req = 1'b1; i_addr = 16'h0010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("f_i_gnt", i_gnt, 1);
      chk("f_busy", busy, (k == 0) ? 0 : 1);
      chk("f_mem_addr", mem_addr, 16'h0010);
      iq.push_back(16'h1234);
      step();
    end
    i_req = 1'b0;
    @(negedge clk);
    chk("f_tail_i_gnt", i_gnt, 0);
    chk("f_tail_busy", busy, 1);
    step();
    @(negedge clk);
    chk("f_idle_busy", busy, 0);
    step();

    // Simultaneous load and fetch: data first, fetch next cycle.
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
    i_req = 1'b1; i_addr = 16'h0012;
    @(negedge clk);
    chk("lf_d_gnt", d_gnt, 1);
    chk("lf_i_gnt", i_gnt, 0);
    chk("lf_mem_addr", mem_addr, 16'h0200);
    chk("lf_mem_we", mem_we, 0);
    dq.push_back(16'hA5A5);
    step();
    d_req = 1'b0;
    @(negedge clk);
    chk("lf_i_gnt2", i_gnt, 1);
    chk("lf_d_rvalid", d_rvalid, 1);
    chk("lf_mem_addr2", mem_addr, 16'h0012);
    iq.push_back(16'h5678);
    step();
    i_req = 1'b0;
    @(negedge clk);
    chk("lf_i_rvalid", i_rvalid, 1);
    step();

    // Store then fetch: one write cycle, one bubble, then fetch.
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0300; d_wdata = 16'hBEEF;
    i_req = 1'b1; i_addr = 16'h0010;
    @(negedge clk);
    chk("st_d_gnt", d_gnt, 1);
    chk("st_i_gnt", i_gnt, 0);
    chk("st_mem_we", mem_we, 1);
    chk("st_mem_addr", mem_addr, 16'h0300);
    chk("st_mem_wdata", mem_wdata, 16'hBEEF);
    step();
    d_req = 1'b0; d_we = 1'b0; d_wdata = 16'h0000;
    @(negedge clk);
    chk("rec_gnts", {i_gnt, d_gnt}, 0);
    chk("rec_mem_we", mem_we, 0);
    chk("rec_busy", busy, 1);
    step();
    @(negedge clk);
    chk("st_i_gnt_late", i_gnt, 1);
    iq.push_back(16'h1234);
    step();
    i_req = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300;
    @(negedge clk);
    chk("rb_d_gnt", d_gnt, 1);
    dq.push_back(16'hBEEF);
    step();
    d_req = 1'b0;
    @(negedge clk);
    step();

    // Continuous loads against a waiting fetch.
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
    i_req = 1'b1; i_addr = 16'h0012;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_i = GUARD && (k == 5);
      chk("sv_i_gnt", i_gnt, exp_i);
      chk("sv_d_gnt", d_gnt, !exp_i);
      if (i_gnt) iq.push_back(16'h5678);
      if (d_gnt) dq.push_back(16'hA5A5);
      step();
    end
    d_req = 1'b0; i_req = 1'b0;
    @(negedge clk);
    step();

    // Reset asserted the cycle after a load grant.
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
    @(negedge clk);
    chk("mr_d_gnt", d_gnt, 1);
    step();
    d_req = 1'b0;
    i_req = 1'b1; i_addr = 16'h0010;
    #1;
    reset_n = 1'b0;
    @(negedge clk);
    chk("mr_d_rvalid", d_rvalid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_i_gnt", i_gnt, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("mr_i_gnt_after", i_gnt, 1);
    chk("mr_busy_after", busy, 0);
    iq.push_back(16'h1234);
    step();
    i_req = 1'b0;
    @(negedge clk);
    step();
    step();

    chk("iq_drained", iq.size(), 0);
    chk("dq_drained", dq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
